// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner types for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_M} arb_owner_t;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: M-priority winner selection with a saturating IF starvation guard
module mem_arb_select #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req,
  input  logic m_req,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_m
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    grant_m = grant_en & m_req & ((cnt_q < LIM) | ~if_req);
    grant_if = grant_en & if_req & ~grant_m;
    cnt_d = (~if_req | grant_if) ? '0 : (grant_m && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF reads and M reads/writes
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEMDATAWIDTH = 32,
  parameter int MEMDEPTH     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          if_req_i,
  input  logic [$clog2(MEMDEPTH)-1:0]   if_pos_i,
  output logic                          if_gnt_o,
  output logic [MEMDATAWIDTH-1:0]       if_rdata_o,
  output logic                          if_rvalid_o,
  input  logic                          m_req_i,
  input  logic                          m_we_i,
  input  logic [$clog2(MEMDEPTH)-1:0]   m_pos_i,
  input  logic [MEMDATAWIDTH-1:0]       m_wdata_i,
  input  logic [MEMDATAWIDTH/8-1:0]     m_wstrb_i,
  output logic                          m_gnt_o,
  output logic [MEMDATAWIDTH-1:0]       m_rdata_o,
  output logic                          m_rvalid_o,
  output logic                          mem_read_en_o,
  output logic                          mem_write_en_o,
  output logic [$clog2(MEMDEPTH)-1:0]   mem_pos_o,
  output logic [MEMDATAWIDTH-1:0]       mem_wdata_o,
  output logic [MEMDATAWIDTH/8-1:0]     mem_wstrb_o,
  input  logic [MEMDATAWIDTH-1:0]       mem_read_data_i,
  input  logic                          mem_read_valid_i
);
  localparam int MD = $clog2(MEMDEPTH);
  localparam int MW = MEMDATAWIDTH;
  localparam int SW = MW / 8;
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic we_q, we_d;
  logic [MD-1:0] pos_q, pos_d;
  logic [MW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic grant_if, grant_m, grant_en, issue, resp;
  assign grant_en = (state_q == IDLE) & ~rst_i;
  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req   (if_req_i),
    .m_req    (m_req_i),
    .grant_en (grant_en),
    .grant_if (grant_if),
    .grant_m  (grant_m)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d = we_q;
    pos_d = pos_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (grant_if | grant_m) begin
        owner_d = grant_m ? OWN_M : OWN_IF;
        we_d = grant_m & m_we_i;
        pos_d = grant_m ? m_pos_i : if_pos_i;
        wdata_d = m_wdata_i;
        wstrb_d = m_wstrb_i;
        state_d = ISSUE;
      end
      ISSUE: state_d = we_q ? IDLE : WAIT;
      WAIT: if (mem_read_valid_i) begin
        rdata_d = mem_read_data_i;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q <= 1'b0;
      pos_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      pos_q <= pos_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end
  assign issue = state_q == ISSUE;
  assign resp = state_q == RESP;
  assign if_gnt_o = grant_if;
  assign m_gnt_o = grant_m;
  assign mem_read_en_o = issue & ~we_q;
  assign mem_write_en_o = issue & we_q;
  assign mem_pos_o = issue ? pos_q : '0;
  assign mem_wdata_o = mem_write_en_o ? wdata_q : '0;
  assign mem_wstrb_o = mem_write_en_o ? wstrb_q : '0;
  assign if_rvalid_o = resp & (owner_q == OWN_IF);
  assign m_rvalid_o = resp & (owner_q == OWN_M);
  assign if_rdata_o = if_rvalid_o ? rdata_q : '0;
  assign m_rdata_o = m_rvalid_o ? rdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and memory against a transaction-level model
module tb_mem_port_arbiter;
  localparam int MD = 10;
  localparam int LIM = 4;
  localparam int BIG = 1 << 30;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic if_req_i, if_gnt_o, if_rvalid_o;
  logic [MD-1:0] if_pos_i;
  logic [31:0] if_rdata_o;
  logic m_req_i, m_we_i, m_gnt_o, m_rvalid_o;
  logic [MD-1:0] m_pos_i;
  logic [31:0] m_wdata_i, m_rdata_o;
  logic [3:0] m_wstrb_i;
  logic mem_read_en_o, mem_write_en_o, mem_read_valid_i;
  logic [MD-1:0] mem_pos_o;
  logic [31:0] mem_wdata_o, mem_read_data_i;
  logic [3:0] mem_wstrb_o;
  mem_port_arbiter #(.MEMDATAWIDTH(32), .MEMDEPTH(1024), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_pos_i(if_pos_i), .if_gnt_o(if_gnt_o),
    .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_pos_i(m_pos_i), .m_wdata_i(m_wdata_i),
    .m_wstrb_i(m_wstrb_i), .m_gnt_o(m_gnt_o), .m_rdata_o(m_rdata_o), .m_rvalid_o(m_rvalid_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o), .mem_pos_o(mem_pos_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_read_data_i(mem_read_data_i), .mem_read_valid_i(mem_read_valid_i)
  );
  always #5 clk_i = ~clk_i;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] mem [1024];
  bit if_pend, m_pend, m_we_r;
  logic [MD-1:0] if_pos_r, m_pos_r;
  logic [31:0] m_wdata_r;
  logic [3:0] m_wstrb_r;
  int cyc, free_at, s_cyc, r_cyc, vld_cyc, rd_g, streak, n_rst;
  bit rd_out, rd_m, r_m, s_we, late_vld, want_reset;
  logic [MD-1:0] s_pos, rd_pos;
  logic [31:0] s_wdata, r_data;
  logic [3:0] s_wstrb;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({if_gnt_o, m_gnt_o, mem_read_en_o, mem_write_en_o, if_rvalid_o, m_rvalid_o}), 64'd0);
    check({tag, "_mem"}, 64'({mem_pos_o, mem_wstrb_o, mem_wdata_o}), 64'd0);
    check({tag, "_rdata"}, {if_rdata_o, m_rdata_o}, 64'd0);
  endtask
  task automatic drive_reqs();
    if_req_i = if_pend;
    if_pos_i = if_pos_r;
    m_req_i = m_pend;
    m_we_i = m_we_r;
    m_pos_i = m_pos_r;
    m_wdata_i = m_wdata_r;
    m_wstrb_i = m_wstrb_r;
  endtask
  task automatic step(input int p_if, input int p_m);
    bit gi, gm, s_act, vld;
    logic [31:0] vdata;
    @(negedge clk_i);
    rst_i = 1'b0;
    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1'b1;
      if_pos_r = 10'($urandom);
    end
    if (!m_pend && $urandom_range(99) < p_m) begin
      m_pend = 1'b1;
      m_we_r = 1'($urandom);
      m_pos_r = 10'($urandom_range(15));
      m_wdata_r = $urandom;
      m_wstrb_r = 4'($urandom);
    end
    drive_reqs();
    vld = (cyc == vld_cyc) || late_vld || (!rd_out && $urandom_range(9) == 0);
    vdata = (cyc == vld_cyc) ? mem[rd_pos] : $urandom;
    late_vld = 1'b0;
    mem_read_valid_i = vld;
    mem_read_data_i = vdata;
    #1;
    s_act = cyc == s_cyc;
    gm = cyc >= free_at && m_pend && (streak < LIM || !if_pend);
    gi = cyc >= free_at && if_pend && !gm;
    check("gnt", 64'({if_gnt_o, m_gnt_o}), 64'({gi, gm}));
    check("strobe", 64'({mem_read_en_o, mem_write_en_o, mem_pos_o}), s_act ? 64'({!s_we, s_we, s_pos}) : 64'd0);
    check("wdata", 64'({mem_wdata_o, mem_wstrb_o}), (s_act && s_we) ? 64'({s_wdata, s_wstrb}) : 64'd0);
    check("if_resp", 64'({if_rvalid_o, if_rdata_o}), (cyc == r_cyc && !r_m) ? 64'({1'b1, r_data}) : 64'd0);
    check("m_resp", 64'({m_rvalid_o, m_rdata_o}), (cyc == r_cyc && r_m) ? 64'({1'b1, r_data}) : 64'd0);
    if (s_act && s_we)
      for (int b = 0; b < 4; b++) if (s_wstrb[b]) mem[s_pos][8*b +: 8] = s_wdata[8*b +: 8];
    if (cyc == vld_cyc) begin
      r_cyc = cyc + 1;
      r_m = rd_m;
      r_data = vdata;
      free_at = cyc + 2;
      rd_out = 1'b0;
    end
    if (gi || gm) begin
      s_cyc = cyc + 1;
      s_we = gm && m_we_r;
      s_pos = gm ? m_pos_r : if_pos_r;
      s_wdata = m_wdata_r;
      s_wstrb = m_wstrb_r;
      if (s_we) free_at = cyc + 2;
      else begin
        rd_out = 1'b1;
        rd_m = gm;
        rd_pos = s_pos;
        rd_g = cyc;
        vld_cyc = cyc + 1 + int'($urandom_range(6, 1));
        free_at = BIG;
      end
    end
    streak = (!if_pend || gi) ? 0 : gm ? (streak == LIM ? LIM : streak + 1) : streak;
    if (gi) if_pend = 1'b0;
    if (gm) m_pend = 1'b0;
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_read_valid_i = 1'b1;
    mem_read_data_i = $urandom;
    #1;
    check_zero("rst_wait");
    @(negedge clk_i);
    #1;
    check_zero("rst_hold");
    cyc += 2;
    free_at = cyc;
    rd_out = 1'b0;
    vld_cyc = -1;
    s_cyc = -1;
    r_cyc = -1;
    streak = 0;
    late_vld = 1'b1;
    n_rst++;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    if_pend = 1'b1;
    if_pos_r = 10'h010;
    m_pend = 1'b1;
    m_we_r = 1'b0;
    m_pos_r = 10'h3FF;
    m_wdata_r = 32'h12345678;
    m_wstrb_r = 4'b0011;
    drive_reqs();
    mem_read_valid_i = 1'b0;
    mem_read_data_i = '0;
    cyc = 0;
    free_at = 0;
    s_cyc = -1;
    r_cyc = -1;
    vld_cyc = -1;
    rd_g = 0;
    streak = 0;
    n_rst = 0;
    rd_out = 1'b0;
    late_vld = 1'b0;
    want_reset = 1'b0;
    @(negedge clk_i);
    #1;
    check_zero("reset");
    for (int i = 0; i < 3000; i++) begin
      if (i == 500 || i == 2500) want_reset = 1'b1;
      if (want_reset && rd_out && cyc >= rd_g + 2) begin
        do_reset();
        want_reset = 1'b0;
      end
      if (i < 1000) step(40, 40);
      else if (i < 1700) step(100, 100);
      else step(30, 70);
    end
    check("reset_count", 64'(n_rst), 64'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
